// File: rtl/opnd_skew_feeder_if.sv
// Feeder-side bundle: start/stall control, SRAM read port and skewed operand/phase outputs.
// slave = feeder, master = controller/array/SRAM side.
interface opnd_skew_feeder_if #(
  parameter int SRAM_BWIDTH  = 256,
  parameter int NUM_LANES    = 32,
  parameter int ADDR_BWIDTH  = 10,
  parameter int K_LEN_BWIDTH = 10
);
  logic                    STALL;
  logic                    START_in;
  logic [ADDR_BWIDTH-1:0]  BASE_ADDR_in;
  logic [K_LEN_BWIDTH-1:0] K_LEN_in;
  logic                    SRAM_RD_EN_out;
  logic [ADDR_BWIDTH-1:0]  SRAM_RD_ADDR_out;
  logic [SRAM_BWIDTH-1:0]  SRAM_RD_DATA_in;
  logic [SRAM_BWIDTH-1:0]  OPND_DATA_out;
  logic [NUM_LANES-1:0]    OPND_IS_VALID_out;
  logic                    IS_COMPUTING_out;
  logic                    IS_FLUSHING_out;
  logic                    BUSY_out;
  logic                    DONE_out;

  modport slave (
    input  STALL, START_in, BASE_ADDR_in, K_LEN_in, SRAM_RD_DATA_in,
    output SRAM_RD_EN_out, SRAM_RD_ADDR_out, OPND_DATA_out, OPND_IS_VALID_out,
           IS_COMPUTING_out, IS_FLUSHING_out, BUSY_out, DONE_out
  );

  modport master (
    output STALL, START_in, BASE_ADDR_in, K_LEN_in, SRAM_RD_DATA_in,
    input  SRAM_RD_EN_out, SRAM_RD_ADDR_out, OPND_DATA_out, OPND_IS_VALID_out,
           IS_COMPUTING_out, IS_FLUSHING_out, BUSY_out, DONE_out
  );
endinterface

// File: rtl/opnd_skew_feeder.sv
// Streams K_LEN SRAM rows into a diagonal skew (lane i delayed i cycles; address -> lane i out = 2+i cycles) and sequences COMPUTE/FLUSH.
// STALL freezes all state, a 1-entry hold catches in-flight read data; define SKEW_ZERO_GATE_EN to force invalid lanes to zero.
module opnd_skew_feeder #(
  parameter int SRAM_BWIDTH  = 256,
  parameter int OPND_BWIDTH  = 8,
  parameter int NUM_LANES    = 32,
  parameter int ADDR_BWIDTH  = 10,
  parameter int K_LEN_BWIDTH = 10,
  parameter int FLUSH_CYCLES = 32
) (
  input logic               CLK,
  input logic               RST,
  opnd_skew_feeder_if.slave bus
);

  localparam int DRAIN_CW   = $clog2(NUM_LANES + 1);
  localparam int FLUSH_CW   = $clog2(FLUSH_CYCLES + 1);
  localparam int CW_A       = (K_LEN_BWIDTH > DRAIN_CW) ? K_LEN_BWIDTH : DRAIN_CW;
  localparam int CNT_BWIDTH = (CW_A > FLUSH_CW) ? CW_A : FLUSH_CW;

  // Skew chain is empty NUM_LANES+1 cycles after the last read issues.
  localparam logic [CNT_BWIDTH-1:0] DRAIN_LAST = CNT_BWIDTH'(NUM_LANES);
  localparam logic [CNT_BWIDTH-1:0] FLUSH_LAST = CNT_BWIDTH'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [CNT_BWIDTH-1:0]   r_cnt;
  logic [CNT_BWIDTH-1:0]   r_fetch_last;
  logic [ADDR_BWIDTH-1:0]  r_addr;
  logic                    r_rd_en;
  logic                    r_flush;
  logic                    r_busy;
  logic                    r_done;

  logic                    r_rd_pend;
  logic                    r_hold_vld;
  logic [SRAM_BWIDTH-1:0]  r_hold;

  logic                    w_rd_en;
  logic                    w_in_vld;
  logic [SRAM_BWIDTH-1:0]  w_in_dat;
  logic [SRAM_BWIDTH-1:0]  w_opnd_dat;
  logic [NUM_LANES-1:0]    w_opnd_vld;

  assign w_rd_en = r_rd_en & ~bus.STALL;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_fetch_last <= '0;
      r_addr       <= '0;
      r_rd_en      <= 1'b0;
      r_flush      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (!bus.STALL) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START_in) begin
            r_addr       <= bus.BASE_ADDR_in;
            r_fetch_last <= CNT_BWIDTH'(bus.K_LEN_in) - CNT_BWIDTH'(1);
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            if (bus.K_LEN_in == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rd_en <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (r_cnt == r_fetch_last) begin
            r_rd_en <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt  <= r_cnt + CNT_BWIDTH'(1);
            r_addr <= r_addr + ADDR_BWIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == DRAIN_LAST) begin
            r_cnt   <= '0;
            r_flush <= 1'b1;
            r_state <= S_FLUSH;
          end else begin
            r_cnt <= r_cnt + CNT_BWIDTH'(1);
          end
        end
        S_FLUSH: begin
          if (r_cnt == FLUSH_LAST) begin
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_BWIDTH'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A read issued just before a stall returns data while the chain is frozen; park it until the stall drops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_pend  <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (bus.STALL) begin
        if (r_rd_pend) begin
          r_hold     <= bus.SRAM_RD_DATA_in;
          r_hold_vld <= 1'b1;
        end
      end else begin
        r_hold_vld <= 1'b0;
      end
    end
  end

  assign w_in_vld = r_hold_vld | r_rd_pend;
  assign w_in_dat = r_hold_vld ? r_hold : bus.SRAM_RD_DATA_in;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [OPND_BWIDTH-1:0] r_dat [0:gi];
    logic                   r_vld [0:gi];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        for (int j = 0; j <= gi; j++) begin
          r_dat[j] <= '0;
          r_vld[j] <= 1'b0;
        end
      end else if (!bus.STALL) begin
        if (w_in_vld) begin
          r_dat[0] <= w_in_dat[gi*OPND_BWIDTH +: OPND_BWIDTH];
        end
        r_vld[0] <= w_in_vld;
        for (int j = 1; j <= gi; j++) begin
          r_dat[j] <= r_dat[j-1];
          r_vld[j] <= r_vld[j-1];
        end
      end
    end

    assign w_opnd_vld[gi] = r_vld[gi];
`ifdef SKEW_ZERO_GATE_EN
    assign w_opnd_dat[gi*OPND_BWIDTH +: OPND_BWIDTH] = r_vld[gi] ? r_dat[gi] : '0;
`else
    assign w_opnd_dat[gi*OPND_BWIDTH +: OPND_BWIDTH] = r_dat[gi];
`endif
  end

  assign bus.SRAM_RD_EN_out    = w_rd_en;
  assign bus.SRAM_RD_ADDR_out  = r_addr;
  assign bus.OPND_DATA_out     = w_opnd_dat;
  assign bus.OPND_IS_VALID_out = w_opnd_vld;
  assign bus.IS_COMPUTING_out  = |w_opnd_vld;
  assign bus.IS_FLUSHING_out   = r_flush;
  assign bus.BUSY_out          = r_busy;
  assign bus.DONE_out          = r_done;

  // FLUSH only starts once DRAIN has emptied the chain, so the phases are disjoint.
  a_phase_disjoint: assert property (@(posedge CLK) disable iff (RST)
    !(bus.IS_COMPUTING_out && bus.IS_FLUSHING_out));

endmodule

// File: tb/tb_opnd_skew_feeder.sv
// Directed bench for opnd_skew_feeder with 4 lanes and FLUSH_CYCLES=4; inputs change on negedge, outputs sampled 1ns later.
// Cycle t=0 is the cycle START is presented; row r address at t=1+r, lane i of row r at t=3+r+i.
module tb_opnd_skew_feeder;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = N * W;
  localparam int AW = 10;
  localparam int KW = 10;
  localparam int F  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  opnd_skew_feeder_if #(.SRAM_BWIDTH(SW), .NUM_LANES(N), .ADDR_BWIDTH(AW), .K_LEN_BWIDTH(KW)) u_if ();

  opnd_skew_feeder #(
    .SRAM_BWIDTH(SW), .OPND_BWIDTH(W), .NUM_LANES(N),
    .ADDR_BWIDTH(AW), .K_LEN_BWIDTH(KW), .FLUSH_CYCLES(F)
  ) u_dut (
    .CLK(clk),
    .RST(rst),
    .bus(u_if.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] sram_base = '0;
  logic          ff_mode   = 1'b0;
  logic [SW-1:0] sram_q    = '0;

  // SRAM model: row r (addr - base) returns {r,r,r,r}; garbage when nothing was read.
  always @(posedge clk) begin
    logic [AW-1:0] off;
    off = u_if.SRAM_RD_ADDR_out - sram_base;
    if (u_if.SRAM_RD_EN_out) sram_q <= ff_mode ? {SW{1'b1}} : {N{off[7:0]}};
    else                     sram_q <= {N{8'hA5}};
  end
  assign u_if.SRAM_RD_DATA_in = sram_q;

  function automatic logic exp_vld(int t, int k, int i);
    return (t >= 3 + i) && (t <= 2 + i + k);
  endfunction

  task automatic test_reset();
    logic [AW-1:0] base;
    int k;
    base = 10'h010;
    k = 8;
    sram_base = base;
    @(negedge clk); #1;
    checks++; if (u_if.SRAM_RD_EN_out !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b exp=0", u_if.SRAM_RD_EN_out); end
    checks++; if (u_if.SRAM_RD_ADDR_out !== '0) begin errors++; $display("FAIL rst_addr got=%h exp=0", u_if.SRAM_RD_ADDR_out); end
    checks++; if (u_if.OPND_DATA_out !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", u_if.OPND_DATA_out); end
    checks++; if (u_if.OPND_IS_VALID_out !== '0) begin errors++; $display("FAIL rst_vld got=%b exp=0", u_if.OPND_IS_VALID_out); end
    checks++; if ({u_if.IS_COMPUTING_out, u_if.IS_FLUSHING_out, u_if.BUSY_out, u_if.DONE_out} !== 4'b0)
      begin errors++; $display("FAIL rst_ctrl got=%b exp=0000", {u_if.IS_COMPUTING_out, u_if.IS_FLUSHING_out, u_if.BUSY_out, u_if.DONE_out}); end
    rst = 1'b0;
    // Start, then abort with an asynchronous reset in mid-FETCH.
    for (int t = 0; t <= 3; t++) begin
      @(negedge clk);
      u_if.START_in = (t == 0); u_if.BASE_ADDR_in = base; u_if.K_LEN_in = KW'(k);
      #1;
    end
    checks++; if (u_if.SRAM_RD_EN_out !== 1'b1 || u_if.BUSY_out !== 1'b1)
      begin errors++; $display("FAIL mid_fetch rd_en=%b busy=%b exp=1/1", u_if.SRAM_RD_EN_out, u_if.BUSY_out); end
    rst = 1'b1;
    #1;
    checks++; if ({u_if.SRAM_RD_EN_out, u_if.BUSY_out, u_if.IS_COMPUTING_out, u_if.DONE_out} !== 4'b0)
      begin errors++; $display("FAIL async_rst_ctrl got=%b exp=0000", {u_if.SRAM_RD_EN_out, u_if.BUSY_out, u_if.IS_COMPUTING_out, u_if.DONE_out}); end
    checks++; if (u_if.SRAM_RD_ADDR_out !== '0 || u_if.OPND_IS_VALID_out !== '0 || u_if.OPND_DATA_out !== '0)
      begin errors++; $display("FAIL async_rst_dp addr=%h vld=%b dat=%h exp=0", u_if.SRAM_RD_ADDR_out, u_if.OPND_IS_VALID_out, u_if.OPND_DATA_out); end
    // Restart immediately after reset drops: the full sequence must come out.
    for (int t = 0; t <= k + 12; t++) begin
      @(negedge clk);
      rst = 1'b0;
      u_if.START_in = (t == 0);
      #1;
      checks++; if (u_if.SRAM_RD_EN_out !== (t >= 1 && t <= k))
        begin errors++; $display("FAIL restart_rd_en t=%0d got=%b", t, u_if.SRAM_RD_EN_out); end
      if (t >= 1 && t <= k) begin
        checks++; if (u_if.SRAM_RD_ADDR_out !== base + AW'(t - 1))
          begin errors++; $display("FAIL restart_addr t=%0d got=%h exp=%h", t, u_if.SRAM_RD_ADDR_out, base + AW'(t - 1)); end
      end
      for (int i = 0; i < N; i++) begin
        checks++; if (u_if.OPND_IS_VALID_out[i] !== exp_vld(t, k, i))
          begin errors++; $display("FAIL restart_vld t=%0d lane=%0d got=%b exp=%b", t, i, u_if.OPND_IS_VALID_out[i], exp_vld(t, k, i)); end
        if (exp_vld(t, k, i)) begin
          checks++; if (u_if.OPND_DATA_out[i*W +: W] !== 8'(t - 3 - i))
            begin errors++; $display("FAIL restart_dat t=%0d lane=%0d got=%h exp=%h", t, i, u_if.OPND_DATA_out[i*W +: W], 8'(t - 3 - i)); end
        end
      end
      checks++; if (u_if.DONE_out !== (t == k + 10))
        begin errors++; $display("FAIL restart_done t=%0d got=%b", t, u_if.DONE_out); end
    end
  endtask

  task automatic test_basic_stream();
    logic [AW-1:0] exp_addr [3];
    logic [AW-1:0] base;
    int k;
    base = 10'h3FE;
    k = 3;
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000};
    sram_base = base;
    for (int t = 0; t <= k + 12; t++) begin
      @(negedge clk);
      u_if.START_in = (t == 0); u_if.BASE_ADDR_in = base; u_if.K_LEN_in = KW'(k);
      #1;
      checks++; if (u_if.SRAM_RD_EN_out !== (t >= 1 && t <= k))
        begin errors++; $display("FAIL basic_rd_en t=%0d got=%b", t, u_if.SRAM_RD_EN_out); end
      if (t >= 1 && t <= k) begin
        checks++; if (u_if.SRAM_RD_ADDR_out !== exp_addr[t-1])
          begin errors++; $display("FAIL basic_addr t=%0d got=%h exp=%h", t, u_if.SRAM_RD_ADDR_out, exp_addr[t-1]); end
      end
      for (int i = 0; i < N; i++) begin
        checks++; if (u_if.OPND_IS_VALID_out[i] !== exp_vld(t, k, i))
          begin errors++; $display("FAIL basic_vld t=%0d lane=%0d got=%b exp=%b", t, i, u_if.OPND_IS_VALID_out[i], exp_vld(t, k, i)); end
        if (exp_vld(t, k, i)) begin
          checks++; if (u_if.OPND_DATA_out[i*W +: W] !== 8'(t - 3 - i))
            begin errors++; $display("FAIL basic_dat t=%0d lane=%0d got=%h exp=%h", t, i, u_if.OPND_DATA_out[i*W +: W], 8'(t - 3 - i)); end
        end
      end
      checks++; if (u_if.IS_COMPUTING_out !== (t >= 3 && t <= k + 5))
        begin errors++; $display("FAIL basic_computing t=%0d got=%b", t, u_if.IS_COMPUTING_out); end
    end
  endtask

  task automatic test_zero_len();
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      u_if.START_in = (t == 0); u_if.BASE_ADDR_in = 10'h123; u_if.K_LEN_in = '0;
      #1;
      checks++; if (u_if.SRAM_RD_EN_out !== 1'b0)
        begin errors++; $display("FAIL zero_rd_en t=%0d got=%b exp=0", t, u_if.SRAM_RD_EN_out); end
      checks++; if (u_if.DONE_out !== (t == 1) || u_if.BUSY_out !== (t == 1))
        begin errors++; $display("FAIL zero_done t=%0d done=%b busy=%b", t, u_if.DONE_out, u_if.BUSY_out); end
      checks++; if (u_if.IS_COMPUTING_out !== 1'b0 || u_if.IS_FLUSHING_out !== 1'b0)
        begin errors++; $display("FAIL zero_phase t=%0d comp=%b flush=%b exp=0/0", t, u_if.IS_COMPUTING_out, u_if.IS_FLUSHING_out); end
    end
  endtask

  task automatic test_phase_seq();
    int k;
    int nflush;
    k = 5;
    nflush = 0;
    sram_base = 10'h040;
    for (int t = 0; t <= k + 12; t++) begin
      @(negedge clk);
      u_if.START_in = (t == 0); u_if.BASE_ADDR_in = 10'h040; u_if.K_LEN_in = KW'(k);
      #1;
      if (u_if.IS_FLUSHING_out === 1'b1) nflush++;
      checks++; if (u_if.IS_COMPUTING_out !== (t >= 3 && t <= k + 5))
        begin errors++; $display("FAIL phase_computing t=%0d got=%b", t, u_if.IS_COMPUTING_out); end
      checks++; if (u_if.IS_FLUSHING_out !== (t >= k + 6 && t <= k + 9))
        begin errors++; $display("FAIL phase_flushing t=%0d got=%b", t, u_if.IS_FLUSHING_out); end
      checks++; if (u_if.IS_COMPUTING_out === 1'b1 && u_if.IS_FLUSHING_out === 1'b1)
        begin errors++; $display("FAIL phase_overlap t=%0d comp=1 flush=1 exp=not both", t); end
      checks++; if (u_if.DONE_out !== (t == k + 10) || u_if.BUSY_out !== (t >= 1 && t <= k + 10))
        begin errors++; $display("FAIL phase_done t=%0d done=%b busy=%b", t, u_if.DONE_out, u_if.BUSY_out); end
    end
    checks++; if (nflush != F) begin errors++; $display("FAIL phase_flush_len got=%0d exp=%0d", nflush, F); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] base;
    int k;
    int u;
    logic stalled;
    base = 10'h020;
    k = 3;
    sram_base = base;
    for (int t = 0; t <= k + 15; t++) begin
      @(negedge clk);
      stalled = (t >= 3 && t <= 5);
      u_if.START_in = (t == 0); u_if.BASE_ADDR_in = base; u_if.K_LEN_in = KW'(k);
      u_if.STALL = stalled;
      #1;
      // Cycles 4..6 show the frozen cycle-3 state; afterwards everything is 3 cycles late.
      u = (t <= 3) ? t : ((t <= 6) ? 3 : t - 3);
      checks++; if (u_if.SRAM_RD_EN_out !== (!stalled && u >= 1 && u <= k))
        begin errors++; $display("FAIL stall_rd_en t=%0d got=%b", t, u_if.SRAM_RD_EN_out); end
      if (!stalled && u >= 1 && u <= k) begin
        checks++; if (u_if.SRAM_RD_ADDR_out !== base + AW'(u - 1))
          begin errors++; $display("FAIL stall_addr t=%0d got=%h exp=%h", t, u_if.SRAM_RD_ADDR_out, base + AW'(u - 1)); end
      end
      for (int i = 0; i < N; i++) begin
        checks++; if (u_if.OPND_IS_VALID_out[i] !== exp_vld(u, k, i))
          begin errors++; $display("FAIL stall_vld t=%0d lane=%0d got=%b exp=%b", t, i, u_if.OPND_IS_VALID_out[i], exp_vld(u, k, i)); end
        if (exp_vld(u, k, i)) begin
          checks++; if (u_if.OPND_DATA_out[i*W +: W] !== 8'(u - 3 - i))
            begin errors++; $display("FAIL stall_dat t=%0d lane=%0d got=%h exp=%h", t, i, u_if.OPND_DATA_out[i*W +: W], 8'(u - 3 - i)); end
        end
      end
      checks++; if (u_if.DONE_out !== (u == k + 10))
        begin errors++; $display("FAIL stall_done t=%0d got=%b", t, u_if.DONE_out); end
    end
    u_if.STALL = 1'b0;
  endtask

  task automatic test_busy_start();
    logic [AW-1:0] base;
    int k;
    base = 10'h300;
    k = 5;
    sram_base = base;
    for (int t = 0; t <= k + 12; t++) begin
      @(negedge clk);
      // Second START pulses with different parameters, in FETCH and in FLUSH.
      u_if.START_in = (t == 0) || (t == 2) || (t == k + 7);
      u_if.BASE_ADDR_in = (t == 0) ? base : 10'h055;
      u_if.K_LEN_in = (t == 0) ? KW'(k) : KW'(1);
      #1;
      checks++; if (u_if.SRAM_RD_EN_out !== (t >= 1 && t <= k))
        begin errors++; $display("FAIL busy_rd_en t=%0d got=%b", t, u_if.SRAM_RD_EN_out); end
      if (t >= 1 && t <= k) begin
        checks++; if (u_if.SRAM_RD_ADDR_out !== base + AW'(t - 1))
          begin errors++; $display("FAIL busy_addr t=%0d got=%h exp=%h", t, u_if.SRAM_RD_ADDR_out, base + AW'(t - 1)); end
      end
      checks++; if (u_if.DONE_out !== (t == k + 10) || u_if.BUSY_out !== (t >= 1 && t <= k + 10))
        begin errors++; $display("FAIL busy_done t=%0d done=%b busy=%b", t, u_if.DONE_out, u_if.BUSY_out); end
    end
    u_if.START_in = 1'b0;
  endtask

  task automatic test_zero_gate();
    int k;
    k = 2;
    sram_base = '0;
    ff_mode = 1'b1;
    for (int t = 0; t <= k + 8; t++) begin
      @(negedge clk);
      u_if.START_in = (t == 0); u_if.BASE_ADDR_in = '0; u_if.K_LEN_in = KW'(k);
      #1;
      for (int i = 0; i < N; i++) begin
        checks++; if (u_if.OPND_IS_VALID_out[i] !== exp_vld(t, k, i))
          begin errors++; $display("FAIL gate_vld t=%0d lane=%0d got=%b exp=%b", t, i, u_if.OPND_IS_VALID_out[i], exp_vld(t, k, i)); end
        if (exp_vld(t, k, i)) begin
          checks++; if (u_if.OPND_DATA_out[i*W +: W] !== 8'hFF)
            begin errors++; $display("FAIL gate_dat_valid t=%0d lane=%0d got=%h exp=ff", t, i, u_if.OPND_DATA_out[i*W +: W]); end
        end
`ifdef SKEW_ZERO_GATE_EN
        else begin
          checks++; if (u_if.OPND_DATA_out[i*W +: W] !== 8'h00)
            begin errors++; $display("FAIL gate_dat_zero t=%0d lane=%0d got=%h exp=00", t, i, u_if.OPND_DATA_out[i*W +: W]); end
        end
`endif
      end
    end
`ifndef SKEW_ZERO_GATE_EN
    // Ungated lanes keep the last row left in the skew registers.
    checks++; if (u_if.OPND_IS_VALID_out !== '0 || u_if.OPND_DATA_out !== {SW{1'b1}})
      begin errors++; $display("FAIL ungated_stale vld=%b dat=%h exp=0/ffffffff", u_if.OPND_IS_VALID_out, u_if.OPND_DATA_out); end
`endif
    ff_mode = 1'b0;
  endtask

  initial begin
    u_if.STALL        = 1'b0;
    u_if.START_in     = 1'b0;
    u_if.BASE_ADDR_in = '0;
    u_if.K_LEN_in     = '0;
    test_reset();
    test_basic_stream();
    test_zero_len();
    test_phase_seq();
    test_stall();
    test_busy_start();
    test_zero_gate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
